// File: rtl/calc_pkg.sv
// Shared types for the calculator arbiter: ALU opcodes and arbiter FSM states.
package calc_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_OR  = 2'b10,
    OP_CMP = 2'b11
  } calc_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } calc_arb_state_t;

endpackage

// File: rtl/calc_alu.sv
// Combinational 4-function ALU: add, subtract (both wrap mod 2^WIDTH), OR, and
// compare (0 when equal, 1 otherwise).
module calc_alu
  import calc_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    case (calc_op_t'(op))
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_OR:   y = a | b;
      OP_CMP:  y = (a == b) ? '0 : WIDTH'(1);
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/calc_arbiter.sv
// Shares one calc_alu between NREQ valid/ready requesters, one op at a time.
// Define CALC_ARB_FIXED_PRIO_EN for fixed (lowest index wins) priority instead of round-robin.
module calc_arbiter
  import calc_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int NREQ  = 2,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ*2-1:0]     req_op,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_result,
  output logic [IDW-1:0]        rsp_id
);

  // state | meaning
  // IDLE  | waiting for a request; ready offered to the granted requester
  // EXEC  | ALU evaluating the captured operands
  // RESP  | result presented until the consumer takes it
  localparam logic [1:0] ST_IDLE = S_IDLE;
  localparam logic [1:0] ST_EXEC = S_EXEC;
  localparam logic [1:0] ST_RESP = S_RESP;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [1:0]       r_op;
  logic [IDW-1:0]   r_id;
  logic [WIDTH-1:0] r_rsp_result;
  logic [IDW-1:0]   r_rsp_id;

  logic             w_gnt_any;
  logic [IDW-1:0]   w_gnt_idx;
  logic             w_fire;
  logic [WIDTH-1:0] w_sel_a;
  logic [WIDTH-1:0] w_sel_b;
  logic [1:0]       w_sel_op;
  logic [WIDTH-1:0] w_alu_y;

`ifdef CALC_ARB_FIXED_PRIO_EN
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid[k]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = IDW'(k);
      end
    end
  end
`else
  logic [IDW-1:0]  r_last;
  logic [IDW-1:0]  w_start;
  logic [NREQ-1:0] w_rot;

  // Rotate valids so bit 0 is the requester just after the last winner.
  assign w_start = (r_last == IDW'(NREQ - 1)) ? '0 : r_last + 1'b1;
  assign w_rot   = NREQ'({req_valid, req_valid} >> w_start);

  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_gnt_any && w_rot[k]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = IDW'((int'(w_start) + k) % NREQ);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= IDW'(NREQ - 1);
    end else if (w_fire) begin
      r_last <= w_gnt_idx;
    end
  end
`endif

  assign w_fire = (r_state == ST_IDLE) && w_gnt_any;

  always_comb begin
    req_ready = '0;
    if (rst_n && w_fire) begin
      req_ready[w_gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    w_sel_a  = '0;
    w_sel_b  = '0;
    w_sel_op = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (w_gnt_idx == IDW'(k)) begin
        w_sel_a  = req_a[k*WIDTH +: WIDTH];
        w_sel_b  = req_b[k*WIDTH +: WIDTH];
        w_sel_op = req_op[k*2 +: 2];
      end
    end
  end

  calc_alu #(.WIDTH(WIDTH)) u_alu (
    .a  (r_a),
    .b  (r_b),
    .op (r_op),
    .y  (w_alu_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_a          <= '0;
      r_b          <= '0;
      r_op         <= '0;
      r_id         <= '0;
      r_rsp_result <= '0;
      r_rsp_id     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_fire) begin
            r_a     <= w_sel_a;
            r_b     <= w_sel_b;
            r_op    <= w_sel_op;
            r_id    <= w_gnt_idx;
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_rsp_result <= w_alu_y;
          r_rsp_id     <= r_id;
          r_state      <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign rsp_valid  = (r_state == ST_RESP);
  assign rsp_result = r_rsp_result;
  assign rsp_id     = r_rsp_id;

endmodule

// File: tb/tb_calc_arbiter.sv
// Self-checking bench for calc_arbiter: directed vector table, multi-cycle corner
// sequences, and a randomized run against a transaction-level reference model.
module tb_calc_arbiter;

  localparam int W    = 4;
  localparam int NREQ = 2;
  localparam int IDW  = 1;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*W-1:0]     req_a;
  logic [NREQ*W-1:0]     req_b;
  logic [NREQ*2-1:0]     req_op;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [W-1:0]          rsp_result;
  logic [IDW-1:0]        rsp_id;

  int n_checks = 0;
  int n_err    = 0;

  calc_arbiter #(.WIDTH(W), .NREQ(NREQ)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_id     (rsp_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    int id;
    int a;
    int b;
    int op;
    int exp;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
  endtask

  task automatic set_req(input int i, input logic v, input int a, input int b, input int op);
    req_valid[i]     = v;
    req_a[i*W +: W]  = W'(a);
    req_b[i*W +: W]  = W'(b);
    req_op[i*2 +: 2] = 2'(op);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_reqs();
    rsp_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_ready(input int i);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 20; t++) begin
      #1;
      if (req_ready[i]) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) check("wait_ready_timeout", 0, 1);
  endtask

  task automatic wait_rsp();
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 20; t++) begin
      #1;
      if (rsp_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) check("wait_rsp_timeout", 0, 1);
  endtask

  function automatic int alu_ref(input int a, input int b, input int op);
    int m;
    m = 1 << W;
    case (op)
      0:       return (a + b) % m;
      1:       return (a - b + m) % m;
      2:       return a | b;
      default: return (a == b) ? 0 : 1;
    endcase
  endfunction

  function automatic int pick(input bit pend[NREQ], input int last);
    int idx;
`ifdef CALC_ARB_FIXED_PRIO_EN
    for (int k = 0; k < NREQ; k++) if (pend[k]) return k;
`else
    for (int k = 1; k <= NREQ; k++) begin
      idx = (last + k) % NREQ;
      if (pend[idx]) return idx;
    end
`endif
    return -1;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int got;
    int prev_t;
    int nresp;
    int exp_id;
    bit pend[NREQ];
    int pa[NREQ], pb[NREQ], pop[NREQ];
    int waits[NREQ];
    int last;
    int fire_t;
    int exp_q_id[$];
    int exp_q_res[$];
    int g;
    bit fire;
    bit any;

    vecs[0] = '{0, 9, 8, 0, 1};
    vecs[1] = '{0, 2, 5, 1, 13};
    vecs[2] = '{0, 10, 5, 2, 15};
    vecs[3] = '{0, 7, 7, 3, 0};
    vecs[4] = '{0, 7, 6, 3, 1};
    vecs[5] = '{1, 15, 1, 0, 0};
    vecs[6] = '{1, 0, 1, 1, 15};
    vecs[7] = '{1, 3, 9, 3, 1};

    // Reset with every requester asking
    rsp_ready = 1'b0;
    clear_reqs();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, i + 1, i + 2, 0);
    #12;
    check("reset_req_ready", 32'(req_ready), 0);
    check("reset_rsp_valid", 32'(rsp_valid), 0);
    check("reset_rsp_result", 32'(rsp_result), 0);
    check("reset_rsp_id", 32'(rsp_id), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("reset_first_grant", 32'(req_ready), 1);
    clear_reqs();
    tick();

    // Directed single ops
    for (int v = 0; v < 8; v++) begin
      set_req(vecs[v].id, 1'b1, vecs[v].a, vecs[v].b, vecs[v].op);
      rsp_ready = 1'b1;
      wait_ready(vecs[v].id);
      tick();
      req_valid = '0;
      #1;
      check("single_exec_no_rsp", 32'(rsp_valid), 0);
      check("single_exec_ready", 32'(req_ready), 0);
      tick();
      check("single_rsp_valid", 32'(rsp_valid), 1);
      check("single_rsp_result", 32'(rsp_result), 32'(vecs[v].exp));
      check("single_rsp_id", 32'(rsp_id), 32'(vecs[v].id));
      tick();
      check("single_rsp_done", 32'(rsp_valid), 0);
    end

    // Contention: both valid for six ops
    do_reset();
    set_req(0, 1'b1, 1, 2, 0);
    set_req(1, 1'b1, 5, 3, 1);
    rsp_ready = 1'b1;
    got = 0;
    for (int t = 0; t < 60 && got < 6; t++) begin
      #1;
      if (rsp_valid) begin
`ifdef CALC_ARB_FIXED_PRIO_EN
        exp_id = 0;
`else
        exp_id = got % 2;
`endif
        check("contention_id", 32'(rsp_id), 32'(exp_id));
        check("contention_result", 32'(rsp_result), (exp_id == 0) ? 3 : 2);
        got++;
      end
      tick();
    end
    check("contention_count", 32'(got), 6);
    clear_reqs();

    // Backpressure
    do_reset();
    set_req(0, 1'b1, 12, 5, 1);
    set_req(1, 1'b1, 3, 3, 3);
    rsp_ready = 1'b0;
    wait_rsp();
    check("bp_first_id", 32'(rsp_id), 0);
    check("bp_first_result", 32'(rsp_result), 7);
    for (int t = 0; t < 5; t++) begin
      tick();
      check("bp_hold_valid", 32'(rsp_valid), 1);
      check("bp_hold_result", 32'(rsp_result), 7);
      check("bp_hold_id", 32'(rsp_id), 0);
      check("bp_hold_no_ready", 32'(req_ready), 0);
    end
    rsp_ready = 1'b1;
    tick();
    check("bp_release_valid", 32'(rsp_valid), 0);
`ifdef CALC_ARB_FIXED_PRIO_EN
    check("bp_next_grant", 32'(req_ready), 1);
`else
    check("bp_next_grant", 32'(req_ready), 2);
`endif
    tick();
    check("bp_second_in_exec", 32'(req_ready), 0);
    tick();
    check("bp_second_valid", 32'(rsp_valid), 1);
`ifdef CALC_ARB_FIXED_PRIO_EN
    check("bp_second_id", 32'(rsp_id), 0);
    check("bp_second_result", 32'(rsp_result), 7);
`else
    check("bp_second_id", 32'(rsp_id), 1);
    check("bp_second_result", 32'(rsp_result), 0);
`endif
    clear_reqs();

    // Reset in the middle of an op from requester 1
    do_reset();
    set_req(1, 1'b1, 4, 4, 0);
    rsp_ready = 1'b1;
    wait_ready(1);
    tick();
    rst_n = 1'b0;
    #1;
    check("midrst_rsp_valid", 32'(rsp_valid), 0);
    check("midrst_req_ready", 32'(req_ready), 0);
    tick();
    tick();
    check("midrst_held_valid", 32'(rsp_valid), 0);
    rst_n = 1'b1;
    set_req(0, 1'b1, 1, 1, 0);
    #1;
    check("midrst_prio", 32'(req_ready), 1);
    wait_rsp();
    check("midrst_first_id", 32'(rsp_id), 0);
    check("midrst_first_result", 32'(rsp_result), 2);
    clear_reqs();

    // Throughput with the consumer always ready
    do_reset();
    set_req(0, 1'b1, 3, 4, 0);
    rsp_ready = 1'b1;
    prev_t = -1;
    nresp = 0;
    for (int t = 0; t < 30; t++) begin
      #1;
      if (rsp_valid) begin
        if (prev_t >= 0) check("tput_spacing", 32'(t - prev_t), 3);
        check("tput_result", 32'(rsp_result), 7);
        prev_t = t;
        nresp++;
      end
      tick();
    end
    check("tput_count", 32'(nresp), 10);
    clear_reqs();

    // Randomized traffic against a transaction-level model
    do_reset();
    last = NREQ - 1;
    fire_t = -10;
    for (int i = 0; i < NREQ; i++) begin
      pend[i] = 1'b0;
      pa[i] = 0;
      pb[i] = 0;
      pop[i] = 0;
      waits[i] = 0;
    end
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && ($urandom_range(1, 0) == 1)) begin
          pend[i] = 1'b1;
          pa[i]   = int'($urandom_range(15, 0));
          pb[i]   = int'($urandom_range(15, 0));
          pop[i]  = int'($urandom_range(3, 0));
        end
        set_req(i, pend[i], pa[i], pb[i], pop[i]);
      end
      rsp_ready = ($urandom_range(9, 0) < 7);
      #1;
      any = 1'b0;
      for (int i = 0; i < NREQ; i++) if (pend[i]) any = 1'b1;
      fire = |(req_ready & req_valid);
      check("rnd_ready_subset", 32'(req_ready & ~req_valid), 0);
      check("rnd_accept", 32'(fire), 32'(any && (exp_q_id.size() == 0)));
      g = -1;
      if (fire) begin
        g = pick(pend, last);
        check("rnd_grant", 32'(req_ready), 32'(1 << g));
        exp_q_id.push_back(g);
        exp_q_res.push_back(alu_ref(pa[g], pb[g], pop[g]));
        last = g;
        fire_t = t;
        for (int i = 0; i < NREQ; i++) begin
          if (i == g) waits[i] = 0;
          else if (pend[i]) begin
            waits[i]++;
`ifndef CALC_ARB_FIXED_PRIO_EN
            check("rnd_fairness", 32'(waits[i] <= NREQ - 1), 1);
`endif
          end
        end
      end
      check("rnd_rsp_valid", 32'(rsp_valid), 32'((exp_q_id.size() > 0) && !fire && (t >= fire_t + 2)));
      if (rsp_valid && exp_q_id.size() > 0) begin
        check("rnd_rsp_id", 32'(rsp_id), 32'(exp_q_id[0]));
        check("rnd_rsp_result", 32'(rsp_result), 32'(exp_q_res[0]));
        if (rsp_ready) begin
          void'(exp_q_id.pop_front());
          void'(exp_q_res.pop_front());
        end
      end
      tick();
      if (fire) pend[g] = 1'b0;
    end

    clear_reqs();
    rsp_ready = 1'b1;
    tick();
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
